ql_dsp_mac_seq: RTL and testbench
=================================

// Module: ql_dsp_mac_seq
// PURPOSE
//  Streaming MAC sequencer that sits directly upstream and downstream of the QL_DSPV2 macro.
//  Accepts operand pairs (sample, coeff) over a valid/ready stream and drives the DSP a/b/load_acc/feedback pins.
//  Counts num_taps products per frame, waits for DSP pipeline latency, then captures dsp_z into an output register.
//  Presents one result per frame over a valid/ready stream.
// PARAMETERS
//  A_WIDTH   20  operand A width (DSP a[19:0])
//  B_WIDTH   18  operand B width (DSP b[17:0])
//  Z_WIDTH   38  DSP accumulator result width
//  OUT_WIDTH 16  result width presented on out_z
//  SHIFT     0   right shift applied to dsp_z before output (0..Z_WIDTH-OUT_WIDTH)
//  TAPS_W    8   width of tap counter / num_taps
//  DSP_LAT   1   clock edges from DSP input pins to valid dsp_z (1 = registered output)
// PORTS
//  clk            in   1          clock
//  reset          in   1          synchronous, active-high reset
//  num_taps       in   TAPS_W     taps per frame; sampled on first tap of frame; 0 treated as 1
//  in_valid       in   1          operand pair valid
//  in_ready       out  1          sequencer can accept operand pair
//  in_a           in   A_WIDTH    sample operand (signed)
//  in_b           in   B_WIDTH    coefficient operand (signed)
//  dsp_a          out  A_WIDTH    to DSP a
//  dsp_b          out  B_WIDTH    to DSP b
//  dsp_load_acc   out  1          to DSP load_acc; 1 = accumulator updates this cycle
//  dsp_feedback   out  3          to DSP feedback; 3'b001 = acc := product, 3'b000 = acc += product
//  dsp_z          in   Z_WIDTH    from DSP z[37:0] (signed)
//  out_valid      out  1          result valid
//  out_ready      in   1          downstream accepts result
//  out_z          out  OUT_WIDTH  frame result (signed)
//  out_sat        out  1          result was saturated (0 when QL_MAC_SEQ_SAT_EN undefined)
//  busy           out  1          state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1, out_valid=0, out_z=0, out_sat=0, dsp_a=0, dsp_b=0, dsp_load_acc=0,
//   dsp_feedback=3'b000, busy=0, tap/latency counters=0; in-flight frame discarded.
//  States: IDLE -> ACCUM on first handshake; ACCUM -> DRAIN on last-tap handshake;
//   DRAIN -> HOLD after DSP_LAT+1 edges; HOLD -> IDLE on out_valid&out_ready.
//  in_ready = (state==IDLE || state==ACCUM); low in DRAIN/HOLD (no frame overlap).
//  dsp_* outputs are registered; updated on every edge:
//   - handshake: dsp_a<=in_a, dsp_b<=in_b, dsp_load_acc<=1, dsp_feedback<=(first tap ? 3'b001 : 3'b000)
//   - no handshake: dsp_a/dsp_b hold, dsp_load_acc<=0, dsp_feedback<=3'b000 (bubble, acc holds)
//  Tap count: first tap latches N=max(num_taps,1); frame ends on handshake number N.
//   N=1 goes IDLE -> DRAIN directly.
//  Latency: out_valid rises exactly DSP_LAT+1 edges after the edge of the last-tap handshake;
//   out_z/out_sat captured from dsp_z on that same edge.
//  out_z/out_valid stable while out_valid & !out_ready.
//  Arithmetic: dsp_z signed two's complement; no sign/width checking of inputs beyond truncation to port widths.
// CONFIGURATION
//  QL_MAC_SEQ_SAT_EN defined:
//   out_z = sat_OUT_WIDTH((dsp_z + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT);
//   round half-up, saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1];
//   out_sat=1 when clamped. No extra latency.
//  QL_MAC_SEQ_SAT_EN undefined: out_z = dsp_z[SHIFT+OUT_WIDTH-1:SHIFT] (wrap), out_sat tied 0.
// TESTING
//  (Bench models DSP as registered MAC, DSP_LAT=1.)
//  num_taps=4, pairs (1,2),(3,4),(5,6),(7,8) back-to-back -> out_z=100, out_valid 2 edges after 4th handshake.
//  Same frame with in_valid low 3 cycles between taps 2/3 -> dsp_load_acc=0 in gaps, out_z=100.
//  num_taps=0, pair (-3,5) -> treated as 1 tap, out_z=-15, feedback=3'b001 on that tap.
//  out_ready low 5 cycles after out_valid -> out_z held, in_ready=0 until accept, then IDLE.
//  SAT_EN, SHIFT=0, OUT_WIDTH=16, taps (20000,2),(20000,2) -> out_z=32767, out_sat=1;
//   without macro -> out_z=16'h3880.
//  Assert reset during ACCUM after 2 of 4 taps -> all outputs reset values next edge;
//   new 1-tap frame (2,3) -> out_z=6.

Source files
------------

// File: rtl/ql_dsp_mac_seq.sv
// ql_dsp_mac_seq: valid/ready MAC sequencer feeding a QL_DSPV2 macro and capturing one result per frame.
// Optional feature macro QL_MAC_SEQ_SAT_EN: round half-up and saturate the captured result.
module ql_dsp_mac_seq #(
    parameter int A_WIDTH   = 20,
    parameter int B_WIDTH   = 18,
    parameter int Z_WIDTH   = 38,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 0,
    parameter int TAPS_W    = 8,
    parameter int DSP_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [TAPS_W-1:0]    num_taps,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   in_a,
    input  logic [B_WIDTH-1:0]   in_b,
    output logic [A_WIDTH-1:0]   dsp_a,
    output logic [B_WIDTH-1:0]   dsp_b,
    output logic                 dsp_load_acc,
    output logic [2:0]           dsp_feedback,
    input  logic [Z_WIDTH-1:0]   dsp_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_z,
    output logic                 out_sat,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    localparam int LAT_W = $clog2(DSP_LAT + 1) + 1;

    state_t               state, state_next;
    logic [TAPS_W-1:0]    tap_cnt, tap_total, taps_eff;
    logic [LAT_W-1:0]     lat_cnt;
    logic                 in_fire, out_fire, first_tap, last_tap, drain_done;
    logic [OUT_WIDTH-1:0] z_next;
    logic                 sat_next;

    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign first_tap  = (state == IDLE);
    assign taps_eff   = (num_taps == '0) ? TAPS_W'(1) : num_taps;
    assign last_tap   = first_tap ? (taps_eff == TAPS_W'(1))
                                  : (tap_cnt == tap_total - TAPS_W'(1));
    assign drain_done = (lat_cnt == LAT_W'(DSP_LAT));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_fire) state_next = last_tap ? DRAIN : ACCUM;
            ACCUM:   if (in_fire && last_tap) state_next = DRAIN;
            DRAIN:   if (drain_done) state_next = HOLD;
            HOLD:    if (out_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || (state == ACCUM);
        out_valid = (state == HOLD);
        busy      = (state != IDLE);
    end

    // Tap count is latched on the first tap so num_taps may change mid-frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            tap_cnt   <= '0;
            tap_total <= '0;
            lat_cnt   <= '0;
        end else begin
            if (in_fire) begin
                if (first_tap) tap_total <= taps_eff;
                tap_cnt <= first_tap ? TAPS_W'(1) : tap_cnt + TAPS_W'(1);
            end
            lat_cnt <= (state == DRAIN) ? lat_cnt + LAT_W'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dsp_a        <= '0;
            dsp_b        <= '0;
            dsp_load_acc <= 1'b0;
            dsp_feedback <= 3'b000;
        end else begin
            dsp_load_acc <= in_fire;
            dsp_feedback <= (in_fire && first_tap) ? 3'b001 : 3'b000;
            if (in_fire) begin
                dsp_a <= in_a;
                dsp_b <= in_b;
            end
        end
    end

`ifdef QL_MAC_SEQ_SAT_EN
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [Z_WIDTH:0] RND =
        (SHIFT > 0) ? ((Z_WIDTH + 1)'(1) << RND_SH) : '0;
    localparam logic signed [Z_WIDTH:0] SAT_MAX =
        {{(Z_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [Z_WIDTH:0] SAT_MIN =
        {{(Z_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    logic signed [Z_WIDTH:0] z_round, z_shift;

    // One extra bit keeps the rounding add from overflowing before the clamp.
    always_comb begin
        z_round  = $signed({dsp_z[Z_WIDTH-1], dsp_z}) + RND;
        z_shift  = z_round >>> SHIFT;
        z_next   = z_shift[OUT_WIDTH-1:0];
        sat_next = 1'b0;
        if (z_shift > SAT_MAX) begin
            z_next   = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
            sat_next = 1'b1;
        end else if (z_shift < SAT_MIN) begin
            z_next   = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
            sat_next = 1'b1;
        end
    end
`else
    logic unused_z;

    assign z_next   = dsp_z[SHIFT+OUT_WIDTH-1:SHIFT];
    assign sat_next = 1'b0;
    assign unused_z = ^dsp_z;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_z   <= '0;
            out_sat <= 1'b0;
        end else if (state == DRAIN && drain_done) begin
            out_z   <= z_next;
            out_sat <= sat_next;
        end
    end

endmodule

// File: tb/tb_ql_dsp_mac_seq.sv
// Directed bench for ql_dsp_mac_seq with a registered-MAC model of the DSP (DSP_LAT=1).
module tb_ql_dsp_mac_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  num_taps;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_a;
    logic [17:0] in_b;
    logic [19:0] dsp_a;
    logic [17:0] dsp_b;
    logic        dsp_load_acc;
    logic [2:0]  dsp_feedback;
    logic [37:0] dsp_z;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_z;
    logic        out_sat;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    ql_dsp_mac_seq dut (
        .clk          (clk),
        .reset        (reset),
        .num_taps     (num_taps),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .dsp_a        (dsp_a),
        .dsp_b        (dsp_b),
        .dsp_load_acc (dsp_load_acc),
        .dsp_feedback (dsp_feedback),
        .dsp_z        (dsp_z),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_z        (out_z),
        .out_sat      (out_sat),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Registered MAC standing in for the DSP macro.
    logic signed [37:0] acc;
    always @(posedge clk) begin
        if (reset)
            acc <= '0;
        else if (dsp_load_acc)
            acc <= ((dsp_feedback == 3'b001) ? 38'sd0 : acc)
                   + 38'($signed(dsp_a) * $signed(dsp_b));
    end
    assign dsp_z = acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_tap(input logic [19:0] a, input logic [17:0] b, input logic [2:0] fb);
        @(negedge clk);
        check("in_ready_tap", in_ready, 1'b1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        check("load_acc_tap", dsp_load_acc, 1'b1);
        check("feedback_tap", dsp_feedback, fb);
        check("dsp_a_tap", dsp_a, a);
        check("dsp_b_tap", dsp_b, b);
    endtask

    // Called right after the last-tap handshake; ends on the negedge where out_valid is first high.
    task automatic wait_result(input logic [15:0] exp_z, input logic exp_sat);
        @(negedge clk);
        in_valid = 1'b0;
        check("drain_in_ready", in_ready, 1'b0);
        check("drain_busy", busy, 1'b1);
        check("valid_early0", out_valid, 1'b0);
        @(negedge clk);
        check("valid_early1", out_valid, 1'b0);
        @(negedge clk);
        check("valid_on_time", out_valid, 1'b1);
        check("out_z", out_z, exp_z);
        check("out_sat", out_sat, exp_sat);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(negedge clk);
        check("accept_valid", out_valid, 1'b0);
        check("accept_in_ready", in_ready, 1'b1);
        check("accept_busy", busy, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        num_taps  = 8'd4;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_z", out_z, 16'd0);
        check("rst_load_acc", dsp_load_acc, 1'b0);
        check("rst_feedback", dsp_feedback, 3'b000);
        reset = 1'b0;

        // Back-to-back 4-tap frame: 1*2+3*4+5*6+7*8 = 100
        send_tap(20'd1, 18'd2, 3'b001);
        send_tap(20'd3, 18'd4, 3'b000);
        send_tap(20'd5, 18'd6, 3'b000);
        send_tap(20'd7, 18'd8, 3'b000);
        wait_result(16'd100, 1'b0);
        accept();

        // Same frame with a 3-cycle bubble between taps 2 and 3
        send_tap(20'd1, 18'd2, 3'b001);
        send_tap(20'd3, 18'd4, 3'b000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            check("gap_load_acc", dsp_load_acc, 1'b0);
            check("gap_feedback", dsp_feedback, 3'b000);
            check("gap_dsp_a_hold", dsp_a, 20'd3);
            check("gap_busy", busy, 1'b1);
        end
        send_tap(20'd5, 18'd6, 3'b000);
        send_tap(20'd7, 18'd8, 3'b000);
        wait_result(16'd100, 1'b0);
        accept();

        // num_taps=0 behaves as a single tap: -3*5 = -15
        num_taps = 8'd0;
        send_tap(20'hffffd, 18'd5, 3'b001);
        wait_result(16'hfff1, 1'b0);
        accept();

        // Downstream stall: 10*10 + (-5)*4 = 80 held while out_ready is low
        num_taps  = 8'd2;
        out_ready = 1'b0;
        send_tap(20'd10, 18'd10, 3'b001);
        send_tap(20'hffffb, 18'd4, 3'b000);
        wait_result(16'd80, 1'b0);
        in_valid = 1'b1;
        in_a     = 20'd99;
        in_b     = 18'd99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1'b1);
            check("stall_out_z", out_z, 16'd80);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_load_acc", dsp_load_acc, 1'b0);
        end
        in_valid = 1'b0;
        accept();

        // 2 * 40000 = 80000 = 0x13880: clamps with saturation, wraps without
        num_taps = 8'd2;
        send_tap(20'd20000, 18'd2, 3'b001);
        send_tap(20'd20000, 18'd2, 3'b000);
`ifdef QL_MAC_SEQ_SAT_EN
        wait_result(16'h7fff, 1'b1);
`else
        wait_result(16'h3880, 1'b0);
`endif
        accept();

        // Reset in the middle of a 4-tap frame, then a fresh 1-tap frame 2*3 = 6
        num_taps = 8'd4;
        send_tap(20'd1, 18'd1, 3'b001);
        send_tap(20'd1, 18'd1, 3'b000);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_z", out_z, 16'd0);
        check("mid_rst_out_sat", out_sat, 1'b0);
        check("mid_rst_dsp_a", dsp_a, 20'd0);
        check("mid_rst_dsp_b", dsp_b, 18'd0);
        check("mid_rst_load_acc", dsp_load_acc, 1'b0);
        check("mid_rst_feedback", dsp_feedback, 3'b000);
        @(negedge clk);
        reset    = 1'b0;
        num_taps = 8'd1;
        send_tap(20'd2, 18'd3, 3'b001);
        wait_result(16'd6, 1'b0);
        accept();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
